// File: rtl/ucontroller_pkg.sv
// Shared types and constants for the 4-bit microcontroller sequencer:
// FSM states, T-state encodings, opcode map and default multi-cycle mask.
package ucontroller_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StExec2  = 3'd4,
        StWb     = 3'd5
    } state_e;

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    typedef enum logic [3:0] {
        LD_A    = 4'h0,
        LD_B    = 4'h1,
        ST_A    = 4'h2,
        MOV     = 4'h3,
        AND_OP  = 4'h4,
        OR_OP   = 4'h5,
        XOR_OP  = 4'h6,
        SHL     = 4'h7,
        SHR     = 4'h8,
        ADD     = 4'h9,
        SUB     = 4'hA,
        INV     = 4'hB,
        INC     = 4'hC,
        DEC     = 4'hD,
        CMP     = 4'hE,
        CLR_ACC = 4'hF
    } opcode_e;

    localparam logic [15:0] DEFAULT_MULTI_MASK = (16'h0001 << ADD) | (16'h0001 << SUB);

    // EXEC2 shares the T2 encoding; IDLE reads as T0.
    function automatic logic [1:0] state_to_t(input state_e s);
        logic [1:0] t;
        t = T0;
        case (s)
            StFetch:         t = T0;
            StDecode:        t = T1;
            StExec, StExec2: t = T2;
            StWb:            t = T3;
            default:         t = T0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/opcode_onehot.sv
// Combinational opcode decoder: every opcode value maps to its own control bit.
module opcode_onehot #(
    parameter int unsigned OPC_W  = 4,
    parameter int unsigned CTRL_W = 2**OPC_W
) (
    input  logic [OPC_W-1:0]  opc,
    output logic [CTRL_W-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[opc] = 1'b1;
    end

endmodule

// File: rtl/control_sequencer.sv
// Instruction sequencer with internal T0-T3 ring and registered one-hot control bus,
// accepting opcodes over a valid/ready handshake.
module control_sequencer
    import ucontroller_pkg::*;
#(
    parameter int unsigned        OPC_W      = 4,
    parameter int unsigned        CTRL_W     = 2**OPC_W,
    parameter logic [CTRL_W-1:0]  MULTI_MASK = CTRL_W'(DEFAULT_MULTI_MASK)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OPC_W-1:0]  instruction,
    input  logic              stall,
    output logic [CTRL_W-1:0] control,
    output logic [1:0]        t_state,
    output logic              busy,
    output logic              done
);

    state_e              state_q, state_d;
    logic [OPC_W-1:0]    opc_q, opc_d;
    logic [CTRL_W-1:0]   control_q, control_d;
    logic [CTRL_W-1:0]   decoded;
    logic                accept;

    assign instr_ready = ((state_q == StIdle) || (state_q == StWb)) && !stall;
    assign accept      = instr_valid && instr_ready;

    opcode_onehot #(
        .OPC_W  (OPC_W),
        .CTRL_W (CTRL_W)
    ) u_onehot (
        .opc    (opc_q),
        .onehot (decoded)
    );

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        control_d = control_q;
        // A stall freezes every register; accept is already blocked via instr_ready.
        if (!stall) begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_d = StFetch;
                        opc_d   = instruction;
                    end
                end
                StFetch:  state_d = StDecode;
                StDecode: begin
                    state_d   = StExec;
                    control_d = decoded;
                end
                StExec: begin
                    if (MULTI_MASK[opc_q]) begin
                        state_d = StExec2;
                    end else begin
                        state_d   = StWb;
                        control_d = '0;
                    end
                end
                StExec2: begin
                    state_d   = StWb;
                    control_d = '0;
                end
                StWb: begin
                    if (accept) begin
                        state_d = StFetch;
                        opc_d   = instruction;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d   = StIdle;
                    control_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            opc_q     <= '0;
            control_q <= '0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            control_q <= control_d;
        end
    end

    assign control = control_q;
    assign t_state = state_to_t(state_q);
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StWb);

endmodule
